// File: rtl/conv_sched.sv
// Sequencer for the 2D-convolution datapath: walks output pixels and kernel taps, drives X/W reads and mac_pipe strobes.
// Optional perf counters (busy_cycles, stall_cycles) are enabled by defining CONV_SCHED_PERF_EN.
module conv_sched #(
  parameter int R       = 8,
  parameter int C       = 8,
  parameter int MAXK    = 5,
  parameter int MAC_LAT = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           inputs_loaded,
  input  logic [$clog2(MAXK+1)-1:0]      K,
  output logic                           compute_finished,
  output logic [$clog2(R*C)-1:0]         X_read_addr,
  output logic [$clog2(MAXK*MAXK)-1:0]   W_read_addr,
  output logic                           init_acc,
  output logic                           input_valid,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           k_error
`ifdef CONV_SCHED_PERF_EN
  ,
  output logic [31:0]                    busy_cycles,
  output logic [31:0]                    stall_cycles
`endif
);

  localparam int KW  = $clog2(MAXK + 1);
  localparam int AW  = $clog2(R * C);
  localparam int WAW = $clog2(MAXK * MAXK);
  localparam int TW  = $clog2(MAXK * MAXK + 1);
  localparam int RW  = $clog2(R + 1);
  localparam int CW  = $clog2(C + 1);
  localparam int DW  = (MAC_LAT > 1) ? $clog2(MAC_LAT + 1) : 1;

  typedef enum logic [2:0] {IDLE, INIT, RUN, DRAIN, WRITE, DONE} state_t;

  state_t          state, state_n;
  logic [RW-1:0]   r;
  logic [CW-1:0]   c;
  logic [KW-1:0]   i, j, kl;
  logic [TW-1:0]   run_cnt, taps;
  logic [DW-1:0]   drain_cnt;
  logic            last_tap, last_run, last_col, last_pix, k_legal;

  assign taps     = TW'(kl) * TW'(kl);
  assign last_tap = (i == kl - KW'(1)) && (j == kl - KW'(1));
  assign last_run = (run_cnt == taps - TW'(1));
  assign last_col = (int'(c) == C - int'(kl));
  assign last_pix = last_col && (int'(r) == R - int'(kl));
  assign k_legal  = (K != '0) && (int'(K) <= MAXK) && (int'(K) <= R) && (int'(K) <= C);

  // Addresses always reflect the tap held in (i, j); products are widened so nothing wraps early.
  assign X_read_addr = (state == IDLE) ? '0 :
    AW'(((AW+1)'(r) + (AW+1)'(i)) * (AW+1)'(C) + (AW+1)'(c) + (AW+1)'(j));
  assign W_read_addr = (state == IDLE) ? '0 :
    WAW'((AW+1)'(i) * (AW+1)'(kl) + (AW+1)'(j));

  always_comb begin
    state_n          = state;
    init_acc         = 1'b0;
    input_valid      = 1'b0;
    out_valid        = 1'b0;
    compute_finished = 1'b0;
    case (state)
      IDLE:  if (inputs_loaded) state_n = k_legal ? INIT : DONE;
      INIT: begin
        init_acc = 1'b1;
        state_n  = RUN;
      end
      RUN: begin
        input_valid = 1'b1;
        if (last_run) state_n = (MAC_LAT == 0) ? WRITE : DRAIN;
      end
      DRAIN: if (int'(drain_cnt) == MAC_LAT - 1) state_n = WRITE;
      WRITE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = last_pix ? DONE : INIT;
      end
      DONE: begin
        compute_finished = 1'b1;
        state_n          = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      r         <= '0;
      c         <= '0;
      i         <= '0;
      j         <= '0;
      kl        <= '0;
      run_cnt   <= '0;
      drain_cnt <= '0;
      k_error   <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (inputs_loaded) begin
          kl      <= K;
          r       <= '0;
          c       <= '0;
          i       <= '0;
          j       <= '0;
          k_error <= !k_legal;
        end
        INIT, RUN: begin
          run_cnt   <= (state == INIT) ? '0 : run_cnt + TW'(1);
          drain_cnt <= '0;
          // The address runs one tap ahead of the data, then parks on the last tap.
          if (!last_tap) begin
            if (j == kl - KW'(1)) begin
              j <= '0;
              i <= i + KW'(1);
            end else begin
              j <= j + KW'(1);
            end
          end
        end
        DRAIN: drain_cnt <= drain_cnt + DW'(1);
        WRITE: if (out_ready && !last_pix) begin
          i <= '0;
          j <= '0;
          if (last_col) begin
            c <= '0;
            r <= r + RW'(1);
          end else begin
            c <= c + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CONV_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_cycles  <= '0;
      stall_cycles <= '0;
    end else begin
      if (state != IDLE && busy_cycles != '1) busy_cycles <= busy_cycles + 32'd1;
      if (state == WRITE && !out_ready && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule
